rtc_bus_driver: RTL and testbench



---
 rtl/rtc_bus_driver_if.sv | 28 ++
 rtl/rtc_bus_driver.sv | 134 +++++++++++++
 tb/tb_rtc_bus_driver.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_driver_if.sv
// Bus bundle between the RTC controller and the multiplexed A/D RTC bus driver.
// The slave side is the driver; the master side is the controller plus RTC pads.
interface rtc_bus_driver_if;
  logic       actesc;
  logic       actlec;
  logic [7:0] dirreg;
  logic [7:0] datoreg;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;
  logic       esclisto;
  logic       memorialisto;
  logic [7:0] datolec;

  modport master (
    output actesc, actlec, dirreg, datoreg, ad_in,
    input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, esclisto, memorialisto, datolec
  );

  modport slave (
    input  actesc, actlec, dirreg, datoreg, ad_in,
    output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, esclisto, memorialisto, datolec
  );
endinterface

// File: rtl/rtc_bus_driver.sv
// Multiplexed address/data RTC bus sequencer: four timed phases of T_PH cycles,
// then a completion flag held until the controller drops its request.
module rtc_bus_driver #(
  parameter int unsigned T_PH = 10
) (
  input  logic             clk,
  input  logic             reset,
  rtc_bus_driver_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADR_LO = 3'd1,
    ADR_HI = 3'd2,
    DAT_LO = 3'd3,
    DAT_HI = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(T_PH - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       wr_q, wr_d;
  logic [7:0] datolec_q, datolec_d;

  logic       cs_n, rd_n, wr_n, a_d, ad_oe, esclisto, memorialisto;
  logic [7:0] ad_out;
  logic       phase_end;
  logic       req_match;

  assign phase_end = (cnt_q == LAST_CNT);
  assign req_match = wr_q ? bus.actesc : bus.actlec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= 8'd0;
      data_q    <= 8'd0;
      wr_q      <= 1'b0;
      datolec_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      datolec_q <= datolec_d;
    end
  end

  // Timed phases count up to T_PH-1 then advance; any state change leaves cnt_d at 0.
  always_comb begin
    state_d      = state_q;
    cnt_d        = 8'd0;
    addr_d       = addr_q;
    data_d       = data_q;
    wr_d         = wr_q;
    datolec_d    = datolec_q;
    cs_n         = 1'b1;
    rd_n         = 1'b1;
    wr_n         = 1'b1;
    a_d          = 1'b0;
    ad_oe        = 1'b0;
    ad_out       = 8'd0;
    esclisto     = 1'b0;
    memorialisto = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.actesc || bus.actlec) begin
          addr_d  = bus.dirreg;
          data_d  = bus.datoreg;
          wr_d    = bus.actesc;
          state_d = ADR_LO;
        end
      end
      ADR_LO: begin
        cs_n   = 1'b0;
        wr_n   = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
        if (phase_end) state_d = ADR_HI;
        else           cnt_d   = cnt_q + 8'd1;
      end
      ADR_HI: begin
        ad_oe  = 1'b1;
        ad_out = addr_q;
        if (phase_end) state_d = DAT_LO;
        else           cnt_d   = cnt_q + 8'd1;
      end
      DAT_LO: begin
        a_d  = 1'b1;
        cs_n = 1'b0;
        if (wr_q) begin
          wr_n   = 1'b0;
          ad_oe  = 1'b1;
          ad_out = data_q;
        end else begin
          rd_n = 1'b0;
          // Sample the pads on the final strobe cycle, before rd_n rises.
          if (phase_end) datolec_d = bus.ad_in;
        end
        if (phase_end) state_d = DAT_HI;
        else           cnt_d   = cnt_q + 8'd1;
      end
      DAT_HI: begin
        a_d = 1'b1;
        if (phase_end) state_d = DONE;
        else           cnt_d   = cnt_q + 8'd1;
      end
      DONE: begin
        esclisto     = wr_q;
        memorialisto = ~wr_q;
        if (!req_match) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cs_n         = cs_n;
  assign bus.rd_n         = rd_n;
  assign bus.wr_n         = wr_n;
  assign bus.a_d          = a_d;
  assign bus.ad_oe        = ad_oe;
  assign bus.ad_out       = ad_out;
  assign bus.esclisto     = esclisto;
  assign bus.memorialisto = memorialisto;
  assign bus.datolec      = datolec_q;

endmodule

// File: tb/tb_rtc_bus_driver.sv
// Directed bench for rtc_bus_driver: one instance at T_PH=4, one at T_PH=2.
module tb_rtc_bus_driver;

  logic       clk;
  logic       reset;
  logic       actesc_a, actlec_a, actesc_b, actlec_b;
  logic [7:0] dirreg, datoreg, ad_in;
  logic       use_b;
  int         err_cnt;
  int         chk_cnt;
  logic [7:0] exp_dl [2];

  rtc_bus_driver_if bus4();
  rtc_bus_driver_if bus2();

  assign bus4.actesc  = actesc_a;
  assign bus4.actlec  = actlec_a;
  assign bus4.dirreg  = dirreg;
  assign bus4.datoreg = datoreg;
  assign bus4.ad_in   = ad_in;
  assign bus2.actesc  = actesc_b;
  assign bus2.actlec  = actlec_b;
  assign bus2.dirreg  = dirreg;
  assign bus2.datoreg = datoreg;
  assign bus2.ad_in   = ad_in;

  rtc_bus_driver #(.T_PH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  rtc_bus_driver #(.T_PH(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strb packs {cs_n, wr_n, rd_n, a_d, ad_oe} of the instance under test.
  logic [4:0] strb;
  logic [7:0] obs_out, obs_dl;
  logic       obs_esc, obs_mem;

  always_comb begin
    if (use_b) begin
      strb    = {bus2.cs_n, bus2.wr_n, bus2.rd_n, bus2.a_d, bus2.ad_oe};
      obs_out = bus2.ad_out;
      obs_dl  = bus2.datolec;
      obs_esc = bus2.esclisto;
      obs_mem = bus2.memorialisto;
    end else begin
      strb    = {bus4.cs_n, bus4.wr_n, bus4.rd_n, bus4.a_d, bus4.ad_oe};
      obs_out = bus4.ad_out;
      obs_dl  = bus4.datolec;
      obs_esc = bus4.esclisto;
      obs_mem = bus4.memorialisto;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit s, input bit wr, input logic v);
    if (s) begin
      if (wr) actesc_b = v; else actlec_b = v;
    end else begin
      if (wr) actesc_a = v; else actlec_a = v;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_strb"}, 32'(strb), 32'h1C);
    check({tag, "_flags"}, 32'({obs_esc, obs_mem}), 32'h0);
  endtask

  // Request already raised; the next rising edge starts the cycle.
  task automatic run_cycle(input int t, input bit wr, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] rv, input int drop_at, input int abort_at);
    logic [4:0] exp_strb;
    logic [7:0] exp_d;
    int         ph;
    bit         s;
    bit         aborted;
    s       = (t == 2);
    use_b   = s;
    aborted = 1'b0;
    ad_in   = ~rv;
    for (int i = 0; i < 4 * t; i++) begin
      @(negedge clk);
      ph = i / t;
      case (ph)
        0:       exp_strb = 5'b00101;
        1:       exp_strb = 5'b11101;
        2:       exp_strb = wr ? 5'b00111 : 5'b01010;
        default: exp_strb = 5'b11110;
      endcase
      exp_d = (!wr && i >= 3 * t) ? rv : exp_dl[s];
      check($sformatf("strb_c%0d", i), 32'(strb), 32'(exp_strb));
      if (ph < 2)            check($sformatf("adr_c%0d", i), 32'(obs_out), 32'(a));
      else if (ph == 2 && wr) check($sformatf("dat_c%0d", i), 32'(obs_out), 32'(d));
      check($sformatf("excl_c%0d", i), 32'(strb[0] & ~strb[2]), 32'h0);
      check($sformatf("flags_c%0d", i), 32'({obs_esc, obs_mem}), 32'h0);
      check($sformatf("datolec_c%0d", i), 32'(obs_dl), 32'(exp_d));
      if (!wr) ad_in = (i == 3 * t - 1) ? rv : ~rv;
      if (i == 2) begin dirreg = ~a; datoreg = ~d; end
      if (i == 3) begin dirreg = a;  datoreg = d;  end
      if (i == drop_at) set_req(s, wr, 1'b0);
      if (i == abort_at) begin
        reset    = 1'b0;
        actesc_a = 1'b0;
        actlec_a = 1'b0;
        #1;
        check_idle("abort_async");
        check("abort_out", 32'(obs_out), 32'h0);
        check("abort_datolec", 32'(obs_dl), 32'h0);
        exp_dl[0] = 8'h00;
        exp_dl[1] = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 4 * t + 2; j++) begin
          @(negedge clk);
          check($sformatf("post_abort_%0d", j), 32'({strb, obs_esc}), 32'h38);
        end
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      @(negedge clk);
      check("done_esc", 32'(obs_esc), 32'(wr));
      check("done_mem", 32'(obs_mem), 32'(!wr));
      if (!wr) exp_dl[s] = rv;
      check("done_datolec", 32'(obs_dl), 32'(exp_dl[s]));
    end
  endtask

  task automatic finish_cycle(input bit s, input bit wr, input int hold);
    use_b = s;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("hold_%0d", i), 32'(wr ? obs_esc : obs_mem), 32'h1);
    end
    set_req(s, wr, 1'b0);
    @(negedge clk);
    check_idle("release");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    err_cnt  = 0;
    chk_cnt  = 0;
    use_b    = 1'b0;
    reset    = 1'b0;
    actesc_a = 1'b0; actlec_a = 1'b0;
    actesc_b = 1'b0; actlec_b = 1'b0;
    dirreg   = 8'h00; datoreg = 8'h00; ad_in = 8'h00;
    exp_dl[0] = 8'h00;
    exp_dl[1] = 8'h00;

    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_out", 32'(obs_out), 32'h0);
    check("reset_datolec", 32'(obs_dl), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check_idle("idle");

    // Write 0x59 to register 0x21, flag held three cycles.
    dirreg = 8'h21; datoreg = 8'h59; actesc_a = 1'b1;
    run_cycle(4, 1'b1, 8'h21, 8'h59, 8'h00, -1, -1);
    finish_cycle(1'b0, 1'b1, 3);

    // Read register 0x41, RTC returns 0x23.
    dirreg = 8'h41; actlec_a = 1'b1;
    run_cycle(4, 1'b0, 8'h41, 8'h00, 8'h23, -1, -1);
    finish_cycle(1'b0, 1'b0, 2);

    // Simultaneous requests: write first, then the still-pending read.
    dirreg = 8'h30; datoreg = 8'h6B; actesc_a = 1'b1; actlec_a = 1'b1;
    run_cycle(4, 1'b1, 8'h30, 8'h6B, 8'h00, -1, -1);
    finish_cycle(1'b0, 1'b1, 1);
    run_cycle(4, 1'b0, 8'h30, 8'h6B, 8'h3C, -1, -1);
    finish_cycle(1'b0, 1'b0, 1);

    // Read request withdrawn during ADR_HI: flag lasts one cycle.
    dirreg = 8'h55; actlec_a = 1'b1;
    run_cycle(4, 1'b0, 8'h55, 8'h00, 8'h9A, 5, -1);
    finish_cycle(1'b0, 1'b0, 0);

    // Reset during DAT_LO of a write.
    dirreg = 8'h21; datoreg = 8'h59; actesc_a = 1'b1;
    run_cycle(4, 1'b1, 8'h21, 8'h59, 8'h00, -1, 9);

    // T_PH=2 back-to-back writes, re-raised one cycle after leaving DONE.
    dirreg = 8'h10; datoreg = 8'hA5; actesc_b = 1'b1;
    run_cycle(2, 1'b1, 8'h10, 8'hA5, 8'h00, -1, -1);
    finish_cycle(1'b1, 1'b1, 0);
    dirreg = 8'h11; datoreg = 8'hB6; actesc_b = 1'b1;
    run_cycle(2, 1'b1, 8'h11, 8'hB6, 8'h00, -1, -1);
    finish_cycle(1'b1, 1'b1, 1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
